// File: rtl/boot_copy_ctrl_pkg.sv
// Shared types for the boot copy controller.
//   ADDR_W/DATA_W/BE_W/BURST_W : master port field widths
//   boot_state_t               : copy sequencer states
//   port_req_t                 : one complete master-port request (address, data, strobes)
//   word_addr()                : byte address of word idx from a word-aligned base
package boot_copy_ctrl_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int BE_W    = 4;
  localparam int BURST_W = 8;

  localparam logic [BE_W-1:0]    BE_ALL    = '1;
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    VERIFY,
    NEXT,
    DONE
  } boot_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic               read;
    logic               write;
    logic [BE_W-1:0]    dataena;
    logic [BURST_W-1:0] burstcount;
  } port_req_t;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [ADDR_W-1:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/boot_port_mux.sv
// Master-port ownership mux for the boot copy controller.
//   cpu_own        : 0 = copy engine drives m_*, 1 = CPU passes straight through
//   eng_req        : registered request from the copy engine
//   cpu_*          : CPU-side request fields and returned response
//   m_*            : master-port request fields and incoming response
// While the engine owns the port, CPU requests are dropped and the CPU sees no response.
module boot_port_mux
  import boot_copy_ctrl_pkg::*;
(
  input  logic               cpu_own,
  input  port_req_t          eng_req,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  input  logic               cpu_read,
  input  logic               cpu_write,
  input  logic [BE_W-1:0]    cpu_dataena,
  input  logic [BURST_W-1:0] cpu_burstcount,
  output logic [DATA_W-1:0]  cpu_rdata,
  output logic               cpu_valid,
  output logic [ADDR_W-1:0]  m_addr,
  output logic [DATA_W-1:0]  m_wdata,
  output logic               m_read,
  output logic               m_write,
  output logic [BE_W-1:0]    m_dataena,
  output logic [BURST_W-1:0] m_burstcount,
  input  logic [DATA_W-1:0]  m_rdata,
  input  logic               m_valid
);

  always_comb begin
    m_addr       = eng_req.addr;
    m_wdata      = eng_req.wdata;
    m_read       = eng_req.read;
    m_write      = eng_req.write;
    m_dataena    = eng_req.dataena;
    m_burstcount = eng_req.burstcount;
    cpu_rdata    = '0;
    cpu_valid    = 1'b0;
    if (cpu_own) begin
      m_addr       = cpu_addr;
      m_wdata      = cpu_wdata;
      m_read       = cpu_read;
      m_write      = cpu_write;
      m_dataena    = cpu_dataena;
      m_burstcount = cpu_burstcount;
      cpu_rdata    = m_rdata;
      cpu_valid    = m_valid;
    end
  end

endmodule

// File: rtl/boot_copy_ctrl.sv
// Boot copy sequencer: after reset, copies WORD_CNT words from UFM (SRC_BASE) to RAM
// (DST_BASE) over the master port, one single-beat read then one single-beat write per
// word, then hands the port to the CPU. The CPU is stalled until the copy completes.
// Optional build macro BOOT_COPY_VERIFY_EN adds a read-back of every written word; a
// mismatch sets the sticky boot_err flag without stopping the copy.
// Ports:
//   clk, rst (sync, active low)        restart : re-run the copy from DONE when CPU idle
//   cpu_* : CPU-side port               m_*     : master port
//   boot_done : copy finished (sticky)  boot_err: verify mismatch seen (sticky)
//
// state  | meaning
// IDLE   | one cycle after reset/restart, counter cleared
// RD     | reading source word i, waiting for m_valid
// WR     | writing captured word to destination i, waiting for m_valid
// VERIFY | re-reading destination word i (verify build only)
// NEXT   | request-free gap cycle, i++, pick RD or DONE
// DONE   | CPU owns the port
`ifndef UFM_OFFSET
`define UFM_OFFSET 32'h0001_0000
`endif
`ifndef RAM_OFFSET
`define RAM_OFFSET 32'h2000_0000
`endif

module boot_copy_ctrl
  import boot_copy_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SRC_BASE = 32'(`UFM_OFFSET),
  parameter logic [ADDR_W-1:0] DST_BASE = 32'(`RAM_OFFSET),
  parameter int unsigned       WORD_CNT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  input  logic               cpu_read,
  input  logic               cpu_write,
  input  logic [BE_W-1:0]    cpu_dataena,
  input  logic [BURST_W-1:0] cpu_burstcount,
  output logic [DATA_W-1:0]  cpu_rdata,
  output logic               cpu_valid,
  output logic               cpu_stall,
  output logic [ADDR_W-1:0]  m_addr,
  output logic [DATA_W-1:0]  m_wdata,
  output logic               m_read,
  output logic               m_write,
  output logic [BE_W-1:0]    m_dataena,
  output logic [BURST_W-1:0] m_burstcount,
  input  logic [DATA_W-1:0]  m_rdata,
  input  logic               m_valid,
  output logic               boot_done,
  output logic               boot_err
);

  // WORD_CNT=0 would give a zero-width counter; keep at least one bit.
  localparam int CNT_W = (WORD_CNT == 0) ? 1 : $clog2(WORD_CNT + 1);

  boot_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  port_req_t         req_q, req_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = (WORD_CNT == 0) ? DONE : RD;
      end
      RD: begin
        if (m_valid) begin
          data_d  = m_rdata;
          state_d = WR;
        end
      end
      WR: begin
        if (m_valid) begin
`ifdef BOOT_COPY_VERIFY_EN
          state_d = VERIFY;
`else
          state_d = NEXT;
`endif
        end
      end
`ifdef BOOT_COPY_VERIFY_EN
      VERIFY: begin
        if (m_valid) begin
          if (m_rdata != data_q) err_d = 1'b1;
          state_d = NEXT;
        end
      end
`endif
      NEXT: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_d == CNT_W'(WORD_CNT)) ? DONE : RD;
      end
      DONE: begin
        // A CPU request in the same cycle wins over restart.
        if (restart && !cpu_read && !cpu_write) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);

    // Engine request is decoded from the next state so m_* change on the same edge
    // as the state and a completed request drops immediately.
    req_d = '0;
    case (state_d)
      RD: begin
        req_d.read       = 1'b1;
        req_d.addr       = word_addr(SRC_BASE, ADDR_W'(cnt_d));
        req_d.dataena    = BE_ALL;
        req_d.burstcount = BURST_ONE;
      end
      WR: begin
        req_d.write      = 1'b1;
        req_d.addr       = word_addr(DST_BASE, ADDR_W'(cnt_d));
        req_d.wdata      = data_d;
        req_d.dataena    = BE_ALL;
        req_d.burstcount = BURST_ONE;
      end
`ifdef BOOT_COPY_VERIFY_EN
      VERIFY: begin
        req_d.read       = 1'b1;
        req_d.addr       = word_addr(DST_BASE, ADDR_W'(cnt_d));
        req_d.dataena    = BE_ALL;
        req_d.burstcount = BURST_ONE;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      req_q   <= req_d;
    end
  end

  assign boot_done = done_q;
  assign cpu_stall = ~done_q;
  // Without the verify build nothing ever sets err_q, so boot_err stays 0.
  assign boot_err  = err_q;

  boot_port_mux u_mux (
    .cpu_own        (done_q),
    .eng_req        (req_q),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_dataena    (cpu_dataena),
    .cpu_burstcount (cpu_burstcount),
    .cpu_rdata      (cpu_rdata),
    .cpu_valid      (cpu_valid),
    .m_addr         (m_addr),
    .m_wdata        (m_wdata),
    .m_read         (m_read),
    .m_write        (m_write),
    .m_dataena      (m_dataena),
    .m_burstcount   (m_burstcount),
    .m_rdata        (m_rdata),
    .m_valid        (m_valid)
  );

endmodule

// File: tb/tb_boot_copy_ctrl.sv
// Directed bench for boot_copy_ctrl: 4-word copy with a latency-2 memory model,
// CPU stall/pass-through, mid-copy reset, restart arbitration, WORD_CNT=0 instance
// and (with BOOT_COPY_VERIFY_EN) read-back error detection.
module tb_boot_copy_ctrl;

  localparam logic [31:0] SRC = 32'h0001_0000;
  localparam logic [31:0] DST = 32'h2000_0000;
  localparam int          LAT = 2;
`ifdef BOOT_COPY_VERIFY_EN
  localparam int          WORD_CYC = 7;
  localparam logic [31:0] EXP_ERR  = 32'd1;
`else
  localparam int          WORD_CYC = 5;
  localparam logic [31:0] EXP_ERR  = 32'd0;
`endif

  logic        clk, rst, restart;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_read, cpu_write, cpu_valid, cpu_stall;
  logic [3:0]  cpu_dataena;
  logic [7:0]  cpu_burstcount;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_read, m_write, m_valid;
  logic [3:0]  m_dataena;
  logic [7:0]  m_burstcount;
  logic        boot_done, boot_err;

  logic [31:0] z_cpu_rdata, z_m_addr, z_m_wdata;
  logic        z_cpu_valid, z_cpu_stall, z_m_read, z_m_write, z_done, z_err;
  logic [3:0]  z_m_dataena;
  logic [7:0]  z_m_burstcount;
  logic [31:0] z_zero32;
  logic        z_zero1;
  logic [3:0]  z_zero4;
  logic [7:0]  z_zero8;

  boot_copy_ctrl #(.SRC_BASE(SRC), .DST_BASE(DST), .WORD_CNT(4)) dut (
    .clk(clk), .rst(rst), .restart(restart),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_dataena(cpu_dataena), .cpu_burstcount(cpu_burstcount),
    .cpu_rdata(cpu_rdata), .cpu_valid(cpu_valid), .cpu_stall(cpu_stall),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_read(m_read), .m_write(m_write),
    .m_dataena(m_dataena), .m_burstcount(m_burstcount),
    .m_rdata(m_rdata), .m_valid(m_valid),
    .boot_done(boot_done), .boot_err(boot_err)
  );

  boot_copy_ctrl #(.SRC_BASE(SRC), .DST_BASE(DST), .WORD_CNT(0)) dut0 (
    .clk(clk), .rst(rst), .restart(z_zero1),
    .cpu_addr(z_zero32), .cpu_wdata(z_zero32), .cpu_read(z_zero1), .cpu_write(z_zero1),
    .cpu_dataena(z_zero4), .cpu_burstcount(z_zero8),
    .cpu_rdata(z_cpu_rdata), .cpu_valid(z_cpu_valid), .cpu_stall(z_cpu_stall),
    .m_addr(z_m_addr), .m_wdata(z_m_wdata), .m_read(z_m_read), .m_write(z_m_write),
    .m_dataena(z_m_dataena), .m_burstcount(z_m_burstcount),
    .m_rdata(z_zero32), .m_valid(z_zero1),
    .boot_done(z_done), .boot_err(z_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int overlap_cnt = 0;
  int stall_valid_cnt = 0;
  int bad_addr_cnt = 0;
  int z_req_cnt = 0;
  int mcnt = 0;
  bit corrupt = 1'b0;
  bit seen;
  logic [31:0] ufm [4];
  logic [31:0] ram [4];
  logic [31:0] last_waddr, last_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_src(input logic [31:0] a);
    return (a >= SRC) && (a < SRC + 32'd16);
  endfunction

  function automatic bit in_dst(input logic [31:0] a);
    return (a >= DST) && (a < DST + 32'd16);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] off;
    if (in_src(a)) begin
      off = a - SRC;
      return ufm[off[3:2]];
    end
    if (in_dst(a)) begin
      off = a - DST;
      return ram[off[3:2]];
    end
    return 32'hBAD0_0000;
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    if (in_dst(a)) begin
      off = a - DST;
      // Corrupt mode: bit 0 of destination word 1 is stuck at 1.
      ram[off[3:2]] = (corrupt && off[3:2] == 2'd1) ? (d | 32'd1) : d;
    end else begin
      last_waddr = a;
      last_wdata = d;
    end
  endtask

  // Memory model: m_valid pulses in the LAT-th cycle a request is held.
  initial begin
    m_valid = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (m_valid) mcnt = 0;
      m_valid = 1'b0;
      if (m_read || m_write) begin
        mcnt++;
        if (mcnt == LAT) begin
          m_valid = 1'b1;
          if (m_read) m_rdata = mem_rd(m_addr);
          else mem_wr(m_addr, m_wdata);
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  // Protocol monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (m_read && m_write) overlap_cnt++;
      if (cpu_stall && cpu_valid) stall_valid_cnt++;
      if (cpu_stall && (m_read || m_write) && !in_src(m_addr) && !in_dst(m_addr)) bad_addr_cnt++;
      if (z_m_read || z_m_write) z_req_cnt++;
    end
  end

  task automatic wait_cpu_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cpu_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (boot_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 4; i++) ram[i] = '0;
  endtask

  task automatic chk_ram(input string tag);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_ram%0d", tag, i), ram[i], ufm[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    z_zero32 = '0; z_zero1 = 1'b0; z_zero4 = '0; z_zero8 = '0;
    rst = 1'b0; restart = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_dataena = 4'hF; cpu_burstcount = 8'd1;
    ufm[0] = 32'h1111_0000; ufm[1] = 32'h2222_2222;
    ufm[2] = 32'h3333_4444; ufm[3] = 32'h5555_6666;
    clear_ram();
    last_waddr = '0; last_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_stall", 32'(cpu_stall), 32'd1);
    chk("rst_done", 32'(boot_done), 32'd0);
    chk("rst_err", 32'(boot_err), 32'd0);
    chk("rst_mreq", 32'({m_read, m_write}), 32'd0);
    chk("rst_maddr", m_addr, 32'd0);
    chk("rst_cpu_valid", 32'(cpu_valid), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_z_done", 32'(z_done), 32'd0);

    // Test 1: full copy, per-step port drive and completion timing
    rst = 1'b1;
    @(negedge clk);
    chk("t1_rd", 32'(m_read), 32'd1);
    chk("t1_rd_addr", m_addr, SRC);
    chk("t1_be", 32'(m_dataena), 32'hF);
    chk("t1_burst", 32'(m_burstcount), 32'd1);
    chk("t4_z_done", 32'(z_done), 32'd1);
    chk("t4_z_stall", 32'(z_cpu_stall), 32'd0);
    repeat (2) @(negedge clk);
    chk("t1_wr", 32'({m_read, m_write}), 32'd1);
    chk("t1_wr_addr", m_addr, DST);
    chk("t1_wdata", m_wdata, ufm[0]);
    repeat (WORD_CYC - 3) @(negedge clk);
    chk("t1_next_gap", 32'({m_read, m_write}), 32'd0);
    repeat (3 * WORD_CYC) @(negedge clk);
    chk("t1_done_early", 32'(boot_done), 32'd0);
    chk("t1_stall_early", 32'(cpu_stall), 32'd1);
    @(negedge clk);
    chk("t1_done", 32'(boot_done), 32'd1);
    chk("t1_stall_off", 32'(cpu_stall), 32'd0);
    chk("t1_err", 32'(boot_err), 32'd0);
    chk_ram("t1");

    // Test 2b: CPU read through the port after boot
    cpu_read = 1'b1; cpu_addr = DST + 32'd8;
    wait_cpu_valid(seen);
    chk("t2_valid_seen", 32'(seen), 32'd1);
    chk("t2_rdata", cpu_rdata, ufm[2]);
    chk("t2_maddr", m_addr, DST + 32'd8);
    cpu_read = 1'b0;
    @(negedge clk);
    chk("t2_valid_pulse", 32'(cpu_valid), 32'd0);

    // Test 3 (+2a): CPU read held during copy, reset at word 2
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; cpu_read = 1'b1; cpu_addr = 32'hDEAD_BEE0;
    repeat (1 + 2 * WORD_CYC) @(negedge clk);
    chk("t3_word2_rd", 32'(m_read), 32'd1);
    chk("t3_word2_addr", m_addr, SRC + 32'd8);
    rst = 1'b0;
    clear_ram();
    @(negedge clk);
    chk("t3_rst_mreq", 32'({m_read, m_write}), 32'd0);
    chk("t3_rst_maddr", m_addr, 32'd0);
    chk("t3_rst_wdata", m_wdata, 32'd0);
    chk("t3_rst_stall", 32'(cpu_stall), 32'd1);
    chk("t3_rst_done", 32'(boot_done), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("t3_restart_rd", 32'(m_read), 32'd1);
    chk("t3_restart_addr", m_addr, SRC);
    repeat (4 * WORD_CYC - 1) @(negedge clk);
    cpu_read = 1'b0;
    @(negedge clk);
    chk("t3_done", 32'(boot_done), 32'd1);
    chk_ram("t3");
    chk("t2_no_cpu_valid_in_copy", 32'(stall_valid_cnt), 32'd0);
    chk("t2_engine_addr_only", 32'(bad_addr_cnt), 32'd0);

    // Test 5: restart collides with a CPU write, then restart alone
    cpu_write = 1'b1; cpu_addr = 32'h3000_0010; cpu_wdata = 32'h5A5A_0F0F; restart = 1'b1;
    @(negedge clk);
    chk("t5_restart_ignored", 32'(boot_done), 32'd1);
    chk("t5_stall_off", 32'(cpu_stall), 32'd0);
    restart = 1'b0;
    wait_cpu_valid(seen);
    cpu_write = 1'b0;
    chk("t5_wr_valid", 32'(seen), 32'd1);
    chk("t5_wr_addr", last_waddr, 32'h3000_0010);
    chk("t5_wr_data", last_wdata, 32'h5A5A_0F0F);
    @(negedge clk);
    restart = 1'b1;
    clear_ram();
    @(negedge clk);
    restart = 1'b0;
    chk("t5_done_clr", 32'(boot_done), 32'd0);
    chk("t5_stall_on", 32'(cpu_stall), 32'd1);
    wait_done(seen);
    chk("t5_rerun_done", 32'(seen), 32'd1);
    chk_ram("t5");

    // Test 6: stuck bit in destination word 1
    corrupt = 1'b1;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    wait_done(seen);
    chk("t6_done", 32'(seen), 32'd1);
    chk("t6_err", 32'(boot_err), EXP_ERR);
    chk("t6_ram1", ram[1], ufm[1] | 32'd1);
    repeat (3) @(negedge clk);
    chk("t6_err_sticky", 32'(boot_err), EXP_ERR);
    chk("t6_done_sticky", 32'(boot_done), 32'd1);
    corrupt = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("t6_err_clr", 32'(boot_err), 32'd0);
    wait_done(seen);
    chk("t6_clean_done", 32'(seen), 32'd1);
    chk("t6_clean_err", 32'(boot_err), 32'd0);

    chk("no_rd_wr_overlap", 32'(overlap_cnt), 32'd0);
    chk("t4_z_no_req", 32'(z_req_cnt), 32'd0);
    chk("t4_z_done_hold", 32'(z_done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
